// File: rtl/lsu_mem_if.sv
// lsu_mem_if: request/grant/rvalid data-memory bus between the LSU and memory.
// master (LSU): drives mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o and mem_wstrb_o;
//               samples mem_gnt_i, mem_rvalid_i and mem_rdata_i.
// slave (memory): the mirror image of master.
interface lsu_mem_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [3:0]        mem_wstrb_o;
    logic              mem_gnt_i;
    logic              mem_rvalid_i;
    logic [DATA_W-1:0] mem_rdata_i;
    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );
    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: RV32I load/store unit talking to data memory over a req/gnt/rvalid bus.
// Core side: load_i/store_i/fun3_i/addr_i/wdata_i in; stall_o, rdata_o, rdata_valid_o,
//            access_err_o (misaligned or illegal funct3) and bus_err_o (timeout) out.
// Memory side: lsu_mem_if.master (word address, replicated write data, byte strobes).
module lsu_mem_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              store_i,
    input  logic [2:0]        fun3_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              stall_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rdata_valid_o,
    output logic              access_err_o,
    output logic              bus_err_o,
    lsu_mem_if.master         mem
);
    localparam logic [1:0] S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2, S_DONE = 2'd3;
    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;
    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        fun3_q, fun3_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        strb_q, strb_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              aerr_q, aerr_d, berr_q, berr_d;
    logic              req, legal, misal, accept, busy, tmo, load_done;
    logic [DATA_W-1:0] sh, ext;
    always_comb begin
        req   = load_i | store_i;
        // stores only allow 000..010; loads additionally allow 100 and 101
        legal = !(fun3_i[1] & fun3_i[0]) & !(fun3_i[2] & (fun3_i[1] | !load_i));
        misal = (fun3_i[1:0] == 2'b01 & addr_i[0]) | (fun3_i[1:0] == 2'b10 & |addr_i[1:0]);
        accept = state_q == S_IDLE & req & legal & !misal;
        busy  = state_q == S_REQ | state_q == S_WAIT;
        tmo   = TIMEOUT != 0 && cnt_q >= CW'(TIMEOUT - 1);
        // read data may arrive together with the grant
        load_done = mem.mem_rvalid_i & ((state_q == S_REQ & mem.mem_gnt_i & !we_q) | state_q == S_WAIT);
        sh  = mem.mem_rdata_i >> {addr_q[1:0], 3'b000};
        ext = fun3_q[1] ? sh
            : fun3_q[0] ? {{16{sh[15] & !fun3_q[2]}}, sh[15:0]}
            : {{24{sh[7] & !fun3_q[2]}}, sh[7:0]};
        // completion wins over an expiring timeout in the same cycle
        state_d = state_q == S_IDLE ? (accept ? S_REQ : S_IDLE)
                : state_q == S_REQ  ? (mem.mem_gnt_i & (we_q | mem.mem_rvalid_i) ? S_DONE
                                      : tmo ? S_IDLE : mem.mem_gnt_i ? S_WAIT : S_REQ)
                : state_q == S_WAIT ? (mem.mem_rvalid_i ? S_DONE : tmo ? S_IDLE : S_WAIT)
                : S_IDLE;
        cnt_d   = accept ? '0 : busy ? cnt_q + 1'b1 : cnt_q;
        addr_d  = accept ? addr_i : addr_q;
        fun3_d  = accept ? fun3_i : fun3_q;
        we_d    = accept ? !load_i : we_q;
        wdata_d = !accept ? wdata_q
                : fun3_i[1] ? wdata_i
                : fun3_i[0] ? {2{wdata_i[15:0]}}
                : {4{wdata_i[7:0]}};
        strb_d  = !accept ? strb_q
                : load_i ? 4'b0000
                : fun3_i[1] ? 4'b1111
                : fun3_i[0] ? 4'b0011 << {addr_i[1], 1'b0}
                : 4'b0001 << addr_i[1:0];
        rdata_d = load_done ? ext : rdata_q;
        aerr_d  = state_q == S_IDLE & req & !(legal & !misal);
        berr_d  = busy & state_d == S_IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            fun3_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            rdata_q <= '0;
            aerr_q  <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            fun3_q  <= fun3_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            rdata_q <= rdata_d;
            aerr_q  <= aerr_d;
            berr_q  <= berr_d;
        end
    end
    assign mem.mem_req_o   = state_q == S_REQ;
    assign mem.mem_we_o    = state_q == S_REQ & we_q;
    assign mem.mem_addr_o  = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem.mem_wdata_o = wdata_q;
    assign mem.mem_wstrb_o = state_q == S_REQ ? strb_q : 4'b0000;
    assign stall_o         = accept | busy;
    assign rdata_o         = rdata_q;
    assign rdata_valid_o   = state_q == S_DONE & !we_q;
    assign access_err_o    = aerr_q;
    assign bus_err_o       = berr_q;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: randomized and directed checks of lsu_mem_ctrl against a transaction-level model.
module tb_lsu_mem_ctrl;
    localparam int TMO = 4;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_i = 1'b0, store_i = 1'b0;
    logic [2:0]  fun3_i = '0;
    logic [31:0] addr_i = '0, wdata_i = '0;
    logic        stall_o, rdata_valid_o, access_err_o, bus_err_o;
    logic [31:0] rdata_o;
    logic [31:0] exp_rdata = '0;
    int          n_chk = 0, n_err = 0;
    lsu_mem_if #(.ADDR_W(32), .DATA_W(32)) mem ();
    lsu_mem_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .load_i(load_i), .store_i(store_i), .fun3_i(fun3_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .stall_o(stall_o), .rdata_o(rdata_o),
        .rdata_valid_o(rdata_valid_o), .access_err_o(access_err_o), .bus_err_o(bus_err_o),
        .mem(mem)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    // One core request; memory grants in REQ cycle g+1 and returns data r cycles after the grant.
    task automatic access(input logic ld, input logic st, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] word, input int g, input int r);
        logic        ok, to;
        int          sz, c, last;
        logic [3:0]  es;
        logic [31:0] ew, v, m;
        sz = 1 << f[1:0];
        ok = ld ? (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f inside {3'd0, 3'd1, 3'd2});
        if (ok && (a % sz) != 0) ok = 1'b0;
        es = ld ? 4'b0000 : 4'((32'h1 << sz) - 1) << (a % 4);
        for (int i = 0; i < 4; i++) ew[8*i +: 8] = wd[8*(i % sz) +: 8];
        v = word >> (8 * (a % 4));
        if (ok && sz < 4) begin
            m = (32'h1 << (8 * sz)) - 1;
            v = v & m;
            if (!f[2] && v[8*sz-1]) v = v | ~m;
        end
        @(posedge clk); #1;
        load_i = ld; store_i = st; fun3_i = f; addr_i = a; wdata_i = wd;
        @(negedge clk);
        chk("stall_accept", stall_o, ok);
        chk("req_accept", mem.mem_req_o, 0);
        @(posedge clk); #1;
        load_i = 1'b0; store_i = 1'b0; fun3_i = 3'($urandom); addr_i = $urandom; wdata_i = $urandom;
        if (!ok) begin
            @(negedge clk);
            chk("aerr_pulse", access_err_o, 1);
            chk("aerr_req", mem.mem_req_o, 0);
            chk("aerr_stall", stall_o, 0);
            @(posedge clk); #1;
            @(negedge clk);
            chk("aerr_clear", access_err_o, 0);
            chk("aerr_rdata", rdata_o, exp_rdata);
            return;
        end
        c = ld ? g + 1 + r : g + 1;
        to = c > TMO;
        last = to ? TMO : c;
        for (int k = 1; k <= last + 1; k++) begin
            mem.mem_gnt_i = k == g + 1;
            mem.mem_rvalid_i = ld && k == c;
            mem.mem_rdata_i = (ld && k == c) ? word : $urandom;
            @(negedge clk);
            chk("stall", stall_o, k <= last);
            chk("req", mem.mem_req_o, k <= last && k <= g + 1);
            if (k <= last && k <= g + 1) begin
                chk("addr", mem.mem_addr_o, a & ~32'h3);
                chk("we", mem.mem_we_o, !ld);
                chk("wstrb", mem.mem_wstrb_o, es);
                if (!ld) chk("wdata", mem.mem_wdata_o, ew);
            end
            chk("rvalid_out", rdata_valid_o, k == last + 1 && !to && ld);
            chk("bus_err", bus_err_o, k == last + 1 && to);
            chk("aerr_none", access_err_o, 0);
            if (k == last + 1) begin
                if (ld && !to) exp_rdata = v;
                chk("rdata", rdata_o, exp_rdata);
            end
            @(posedge clk); #1;
        end
        mem.mem_gnt_i = 1'b0;
        mem.mem_rvalid_i = 1'b0;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
    initial begin
        mem.mem_gnt_i = 1'b0; mem.mem_rvalid_i = 1'b0; mem.mem_rdata_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", stall_o, 0);
        chk("rst_req", mem.mem_req_o, 0);
        chk("rst_rdata", rdata_o, 0);
        chk("rst_rvalid", rdata_valid_o, 0);
        chk("rst_aerr", access_err_o, 0);
        chk("rst_berr", bus_err_o, 0);
        chk("rst_wstrb", mem.mem_wstrb_o, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        access(0, 1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 1, 0);
        access(1, 0, 3'b000, 32'h102, 32'h0, 32'h00F20000, 0, 1);
        chk("lb_val", rdata_o, 32'hFFFFFFF2);
        access(1, 0, 3'b100, 32'h102, 32'h0, 32'h00F20000, 0, 0);
        chk("lbu_val", rdata_o, 32'h000000F2);
        access(1, 0, 3'b101, 32'h102, 32'h0, 32'h00F20000, 1, 2);
        chk("lhu_val", rdata_o, 32'h000000F2);
        access(1, 0, 3'b001, 32'h102, 32'h0, 32'h00F20000, 0, 1);
        chk("lh_val", rdata_o, 32'h000000F2);
        access(1, 0, 3'b010, 32'h206, 32'h0, 32'h0, 0, 0);
        access(1, 0, 3'b001, 32'h101, 32'h0, 32'h0, 0, 0);
        access(1, 0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 0);
        access(1, 0, 3'b010, 32'h300, 32'h0, 32'hDEADBEEF, 10, 0);
        chk("tmo_keep", rdata_o, 32'h000000F2);
        access(1, 1, 3'b010, 32'h8, 32'h55AA55AA, 32'hCAFEF00D, 0, 1);
        // reset while the load sits in WAIT
        @(posedge clk); #1;
        load_i = 1'b1; fun3_i = 3'b010; addr_i = 32'h0;
        @(posedge clk); #1;
        load_i = 1'b0; mem.mem_gnt_i = 1'b1;
        @(posedge clk); #1;
        mem.mem_gnt_i = 1'b0;
        @(negedge clk);
        chk("wait_stall", stall_o, 1);
        rst = 1'b1;
        #1;
        chk("arst_req", mem.mem_req_o, 0);
        chk("arst_stall", stall_o, 0);
        chk("arst_rdata", rdata_o, 0);
        exp_rdata = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        mem.mem_rvalid_i = 1'b1; mem.mem_rdata_i = 32'h87654321;
        @(negedge clk);
        chk("stray_rvalid", rdata_valid_o, 0);
        @(posedge clk); #1;
        mem.mem_rvalid_i = 1'b0;
        @(negedge clk);
        chk("stray_rdata", rdata_o, 0);
        chk("stray_rvalid2", rdata_valid_o, 0);
        access(1, 0, 3'b010, 32'h0, 32'h0, 32'h12345678, 0, 1);
        chk("lw_after_rst", rdata_o, 32'h12345678);
        for (int n = 0; n < 300; n++) begin
            logic ld, st;
            ld = 1'($urandom);
            st = ld ? 1'($urandom) : 1'b1;
            access(ld, st, 3'($urandom), {20'h0, 10'($urandom), 2'($urandom)}, $urandom, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3));
        end
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Data-memory responder for the RV32I core's load/store control signals (`load_i`, `store_i`, `fun3_i`). It sits between the execute stage and the data-memory bus.
- Accepts one load or store per transaction and checks alignment and funct3 legality.
- Generates byte strobes and write-data replication, then runs a request/grant/rvalid handshake with memory.
- Returns sign- or zero-extended load data and stalls the core while the bus transaction is outstanding.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; fixed at 32, four byte lanes
- TIMEOUT, 64, max cycles spent in REQ+WAIT before a bus error; 0 disables the timeout

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- load_i  in  1  load request from control decode
- store_i  in  1  store request from control decode
- fun3_i  in  3  funct3 of the load/store
- addr_i  in  ADDR_W  effective byte address from ALU
- wdata_i  in  32  store data (rs2)
- stall_o  out  1  hold PC and pipeline
- rdata_o  out  32  extended load result
- rdata_valid_o  out  1  one-cycle pulse, rdata_o valid
- access_err_o  out  1  one-cycle pulse: misaligned access or illegal funct3
- bus_err_o  out  1  one-cycle pulse: timeout
- mem_req_o  out  1  bus request
- mem_we_o  out  1  1 = write
- mem_addr_o  out  ADDR_W  word-aligned address, bits [1:0] = 0
- mem_wdata_o  out  32  lane-replicated write data
- mem_wstrb_o  out  4  byte strobes; 0 for reads
- mem_gnt_i  in  1  request accepted
- mem_rvalid_i  in  1  read data valid
- mem_rdata_i  in  32  read data

Behaviour:
- Clock and reset: single clock `clk`; reset `rst` is asynchronous, active-high.
- Reset values:
  - state = IDLE.
  - All outputs 0, including rdata_o.
  - Timeout counter 0.
  - Reset asserted mid-transaction drops mem_req_o immediately; the in-flight access is abandoned and no pulse is emitted.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code is illegal.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]≠0.
- load_i and store_i both high: load wins, store ignored.
- State IDLE:
  - On load_i|store_i with an illegal or misaligned access: access_err_o pulses next cycle, no bus request, stall_o stays 0, remain in IDLE.
  - On a legal access: latch addr, fun3, wdata and type; stall_o=1 combinationally in the same cycle; next state REQ.
- State REQ:
  - mem_req_o=1. addr, we, wdata and wstrb are driven from latched values and held stable until grant.
  - mem_gnt_i=1: a store goes to DONE; a load goes to WAIT.
  - mem_rvalid_i in the same cycle as the grant on a load is legal: capture the data and go to DONE.
- State WAIT: mem_req_o=0; on mem_rvalid_i capture the extended data into rdata_o and go to DONE.
- State DONE:
  - stall_o=0; rdata_valid_o=1 for loads only; next state IDLE.
  - New requests are not sampled in DONE; the core re-presents them in IDLE.
- stall_o=1 in REQ and WAIT, and in IDLE only when accepting a legal access.
- Store lanes:
  - SB: wstrb = 0001<<addr[1:0]; wdata = {4{wdata_i[7:0]}}.
  - SH: wstrb = 0011<<{addr[1],1'b0}; wdata = {2{wdata_i[15:0]}}.
  - SW: wstrb = 1111; wdata = wdata_i.
- Load extraction: shift mem_rdata_i right by 8*addr[1:0].
  - LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW passes through.
- Timeout:
  - Counter clears on entry to REQ and increments each cycle in REQ/WAIT.
  - On reaching TIMEOUT without completion: bus_err_o pulses 1 cycle, mem_req_o drops, stall_o drops, go to IDLE, rdata_o unchanged.
  - TIMEOUT=0 waits forever.
- Stray mem_rvalid_i or mem_gnt_i in IDLE/DONE is ignored.
- Latency, zero-wait memory (gnt in REQ cycle, rvalid next cycle):
  - Store: accept → REQ → DONE, 2 stall cycles.
  - Load: accept → REQ → WAIT → DONE, 3 stall cycles.

Test Plan:
- SB to addr 0x103, wdata_i=0x000000A5, gnt after 2 cycles → mem_addr_o=0x100, wstrb=1000, wdata=0xA5A5A5A5 held stable through grant, stall_o high 3 cycles, no rdata_valid_o.
- LB addr 0x102, rdata 0x00F20000 → rdata_o=0xFFFFFFF2; repeat as LBU → 0x000000F2; LHU addr 0x102 → 0x000000F2; LH same → 0x000000F2.
- LW addr 0x206 and LH addr 0x101 → access_err_o single pulse each, mem_req_o never asserts, stall_o 0; fun3=011 load → access_err_o.
- TIMEOUT=4, load with no gnt → bus_err_o pulse 4 cycles after REQ entry, mem_req_o low afterwards, state IDLE, rdata_o keeps prior value.
- rst asserted while in WAIT → mem_req_o, stall_o, rdata_o = 0 asynchronously; a later rvalid is ignored; the next LW to 0x0 with rdata 0x12345678 completes normally.
- load_i and store_i high together at addr 0x8, fun3=010 → read performed (mem_we_o=0, wstrb=0000).
